// File: rtl/alu_exec_pkg.sv
// alu_exec_pkg: shared definitions for the ALU execution unit.
//   op_e    - operation encodings driven on the 'op' port.
//   state_e - sequencing FSM states of alu_exec_unit.
package alu_exec_pkg;

  typedef enum logic [1:0] {
    OP_ADD = 2'd0,
    OP_SUB = 2'd1,
    OP_AND = 2'd2,
    OP_OR  = 2'd3
  } op_e;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    READ  = 3'd1,
    EXEC  = 3'd2,
    WRITE = 3'd3,
    DONE  = 3'd4
  } state_e;

endpackage

// File: rtl/alu_exec_rf.sv
// alu_exec_rf: small register file for the ALU execution unit.
//   i_clk, i_rst              - clock and synchronous active-high clear of all words
//   i_we, i_waddr, i_wdata    - synchronous write port
//   i_raddr_a / o_rdata_a     - combinational read port A
//   i_raddr_b / o_rdata_b     - combinational read port B
module alu_exec_rf
  import alu_exec_pkg::*;
#(
  parameter int unsigned WIDTH  = 8,
  parameter int unsigned AWIDTH = 2
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_we,
  input  logic [AWIDTH-1:0] i_waddr,
  input  logic [WIDTH-1:0]  i_wdata,
  input  logic [AWIDTH-1:0] i_raddr_a,
  output logic [WIDTH-1:0]  o_rdata_a,
  input  logic [AWIDTH-1:0] i_raddr_b,
  output logic [WIDTH-1:0]  o_rdata_b
);

  localparam int unsigned DEPTH = 2 ** AWIDTH;

  logic [WIDTH-1:0] r_mem [DEPTH];

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_mem[i] <= '0;
      end
    end else if (i_we) begin
      r_mem[i_waddr] <= i_wdata;
    end
  end

  assign o_rdata_a = r_mem[i_raddr_a];
  assign o_rdata_b = r_mem[i_raddr_b];

endmodule

// File: rtl/alu_exec_unit.sv
// alu_exec_unit: multi-cycle ALU operating on an internal register file.
//   clk, rst                    - clock, synchronous active-high reset
//   load, load_addr, load_data  - external RF write (honoured only in IDLE)
//   start, op                   - launch one ADD/SUB/AND/OR operation
//   a_addr, b_addr, c_addr      - operand A, operand B and destination addresses
//   busy, done                  - in-flight flag and one-cycle completion pulse
//   result, carry_out, zero     - last completed result and flags
//   op_count                    - completed operations, modulo 256
// Sequence: IDLE -> READ -> EXEC -> WRITE -> DONE -> IDLE.
module alu_exec_unit
  import alu_exec_pkg::*;
#(
  parameter int unsigned WIDTH  = 8,
  parameter int unsigned AWIDTH = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic [AWIDTH-1:0] load_addr,
  input  logic [WIDTH-1:0]  load_data,
  input  logic              start,
  input  logic [1:0]        op,
  input  logic [AWIDTH-1:0] a_addr,
  input  logic [AWIDTH-1:0] b_addr,
  input  logic [AWIDTH-1:0] c_addr,
  output logic              busy,
  output logic              done,
  output logic [WIDTH-1:0]  result,
  output logic              carry_out,
  output logic              zero,
  output logic [7:0]        op_count
);

  state_e            r_state;
  state_e            w_state_next;
  op_e               r_op;
  logic [AWIDTH-1:0] r_a_addr;
  logic [AWIDTH-1:0] r_b_addr;
  logic [AWIDTH-1:0] r_c_addr;
  logic [WIDTH-1:0]  r_opnd_a;
  logic [WIDTH-1:0]  r_opnd_b;
  logic [WIDTH-1:0]  r_result;
  logic              r_carry;
  logic              r_zero;
  logic [7:0]        r_op_count;

  logic              w_rf_we;
  logic [AWIDTH-1:0] w_rf_waddr;
  logic [WIDTH-1:0]  w_rf_wdata;
  logic [WIDTH-1:0]  w_rdata_a;
  logic [WIDTH-1:0]  w_rdata_b;
  logic [WIDTH:0]    w_alu;
  logic              w_accept;

  // Load has priority over start in IDLE.
  assign w_accept = (r_state == IDLE) && start && !load;

  // Shared write port: external load in IDLE, ALU result in WRITE.
  always_comb begin
    w_rf_we    = 1'b0;
    w_rf_waddr = load_addr;
    w_rf_wdata = load_data;
    if (r_state == WRITE) begin
      w_rf_we    = 1'b1;
      w_rf_waddr = r_c_addr;
      w_rf_wdata = r_result;
    end else if (r_state == IDLE) begin
      w_rf_we = load;
    end
  end

  alu_exec_rf #(
    .WIDTH (WIDTH),
    .AWIDTH(AWIDTH)
  ) u_rf (
    .i_clk    (clk),
    .i_rst    (rst),
    .i_we     (w_rf_we),
    .i_waddr  (w_rf_waddr),
    .i_wdata  (w_rf_wdata),
    .i_raddr_a(r_a_addr),
    .o_rdata_a(w_rdata_a),
    .i_raddr_b(r_b_addr),
    .o_rdata_b(w_rdata_b)
  );

  // One extra bit: carry for ADD, borrow (A < B) for SUB.
  always_comb begin
    w_alu = '0;
    unique case (r_op)
      OP_ADD: w_alu = {1'b0, r_opnd_a} + {1'b0, r_opnd_b};
      OP_SUB: w_alu = {1'b0, r_opnd_a} - {1'b0, r_opnd_b};
      OP_AND: w_alu = {1'b0, r_opnd_a & r_opnd_b};
      OP_OR:  w_alu = {1'b0, r_opnd_a | r_opnd_b};
      default: w_alu = '0;
    endcase
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      IDLE:    if (w_accept) w_state_next = READ;
      READ:    w_state_next = EXEC;
      EXEC:    w_state_next = WRITE;
      WRITE:   w_state_next = DONE;
      DONE:    w_state_next = IDLE;
      default: w_state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= IDLE;
      r_op       <= OP_ADD;
      r_a_addr   <= '0;
      r_b_addr   <= '0;
      r_c_addr   <= '0;
      r_opnd_a   <= '0;
      r_opnd_b   <= '0;
      r_result   <= '0;
      r_carry    <= 1'b0;
      r_zero     <= 1'b0;
      r_op_count <= '0;
    end else begin
      r_state <= w_state_next;
      if (w_accept) begin
        r_op     <= op_e'(op);
        r_a_addr <= a_addr;
        r_b_addr <= b_addr;
        r_c_addr <= c_addr;
      end
      if (r_state == READ) begin
        r_opnd_a <= w_rdata_a;
        r_opnd_b <= w_rdata_b;
      end
      if (r_state == EXEC) begin
        r_result <= w_alu[WIDTH-1:0];
        r_carry  <= w_alu[WIDTH];
        r_zero   <= (w_alu[WIDTH-1:0] == '0);
      end
      if (r_state == WRITE) begin
        r_op_count <= r_op_count + 8'd1;
      end
    end
  end

  assign busy      = (r_state != IDLE);
  assign done      = (r_state == DONE);
  assign result    = r_result;
  assign carry_out = r_carry;
  assign zero      = r_zero;
  assign op_count  = r_op_count;

endmodule

// File: tb/tb_alu_exec_unit.sv
module tb_alu_exec_unit;

  logic       clk = 1'b0;
  logic       rst;
  logic       load;
  logic [1:0] load_addr;
  logic [7:0] load_data;
  logic       start;
  logic [1:0] op;
  logic [1:0] a_addr;
  logic [1:0] b_addr;
  logic [1:0] c_addr;
  logic       busy;
  logic       done;
  logic [7:0] result;
  logic       carry_out;
  logic       zero;
  logic [7:0] op_count;

  int n_checks = 0;
  int n_errors = 0;
  int exp_cnt  = 0;

  alu_exec_unit #(
    .WIDTH (8),
    .AWIDTH(2)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .load     (load),
    .load_addr(load_addr),
    .load_data(load_data),
    .start    (start),
    .op       (op),
    .a_addr   (a_addr),
    .b_addr   (b_addr),
    .c_addr   (c_addr),
    .busy     (busy),
    .done     (done),
    .result   (result),
    .carry_out(carry_out),
    .zero     (zero),
    .op_count (op_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0] op;
    logic [7:0] a;
    logic [7:0] b;
    logic [7:0] res;
    logic       c;
    logic       z;
  } vec_t;

  vec_t vecs [8];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [7:0] rf(input int idx);
    return dut.u_rf.r_mem[idx];
  endfunction

  task automatic do_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    exp_cnt = 0;
  endtask

  task automatic do_load(input logic [1:0] addr, input logic [7:0] data);
    load      = 1'b1;
    load_addr = addr;
    load_data = data;
    tick();
    load = 1'b0;
  endtask

  // Launches one operation, checks latency and pulse shape, returns in IDLE.
  task automatic run_op(input logic [1:0] o, input logic [1:0] a, input logic [1:0] b,
                        input logic [1:0] c);
    int lat;
    lat = 99;
    op = o; a_addr = a; b_addr = b; c_addr = c;
    start = 1'b1;
    tick();
    start = 1'b0;
    check("busy_after_start", busy, 1);
    for (int k = 1; k <= 8; k++) begin
      tick();
      if (done) begin
        lat = k;
        break;
      end
    end
    check("done_latency", lat, 3);
    check("busy_in_done", busy, 1);
    tick();
    check("done_one_cycle", done, 0);
    check("busy_back_idle", busy, 0);
    exp_cnt = (exp_cnt + 1) % 256;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    int dones;

    vecs[0] = '{2'd0, 8'h7F, 8'h01, 8'h80, 1'b0, 1'b0};
    vecs[1] = '{2'd0, 8'hFF, 8'h01, 8'h00, 1'b1, 1'b1};
    vecs[2] = '{2'd0, 8'h80, 8'h80, 8'h00, 1'b1, 1'b1};
    vecs[3] = '{2'd1, 8'h05, 8'h07, 8'hFE, 1'b1, 1'b0};
    vecs[4] = '{2'd1, 8'h07, 8'h05, 8'h02, 1'b0, 1'b0};
    vecs[5] = '{2'd1, 8'h07, 8'h07, 8'h00, 1'b0, 1'b1};
    vecs[6] = '{2'd2, 8'hF0, 8'h3C, 8'h30, 1'b0, 1'b0};
    vecs[7] = '{2'd3, 8'hF0, 8'h0F, 8'hFF, 1'b0, 1'b0};

    rst = 1'b1; load = 1'b0; load_addr = '0; load_data = '0;
    start = 1'b0; op = '0; a_addr = '0; b_addr = '0; c_addr = '0;
    tick();
    tick();
    rst = 1'b0;

    // Reset state
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_result", result, 0);
    check("rst_carry", carry_out, 0);
    check("rst_zero", zero, 0);
    check("rst_op_count", op_count, 0);
    for (int i = 0; i < 4; i++) check("rst_rf", rf(i), 0);

    // Table-driven operations: r0 op r1 -> r2
    for (int i = 0; i < 8; i++) begin
      do_load(2'd0, vecs[i].a);
      do_load(2'd1, vecs[i].b);
      run_op(vecs[i].op, 2'd0, 2'd1, 2'd2);
      check("vec_result", result, vecs[i].res);
      check("vec_carry", carry_out, vecs[i].c);
      check("vec_zero", zero, vecs[i].z);
      check("vec_rf_dest", rf(2), vecs[i].res);
      check("vec_op_count", op_count, exp_cnt);
    end

    // Aliasing: r0 = r0 + r1
    do_load(2'd0, 8'hFF);
    do_load(2'd1, 8'h01);
    run_op(2'd0, 2'd0, 2'd1, 2'd0);
    check("alias_result", result, 8'h00);
    check("alias_carry", carry_out, 1);
    check("alias_zero", zero, 1);
    check("alias_r0", rf(0), 8'h00);

    // Flags hold while idle and across loads
    do_load(2'd3, 8'h44);
    tick();
    check("hold_result", result, 8'h00);
    check("hold_carry", carry_out, 1);

    // start and load together in IDLE: load wins
    load = 1'b1; load_addr = 2'd3; load_data = 8'h11;
    start = 1'b1; op = 2'd0; a_addr = 2'd0; b_addr = 2'd1; c_addr = 2'd3;
    tick();
    load = 1'b0; start = 1'b0;
    check("ldst_busy", busy, 0);
    check("ldst_r3", rf(3), 8'h11);
    dones = 0;
    for (int k = 0; k < 6; k++) begin
      tick();
      if (done) dones++;
    end
    check("ldst_no_done", dones, 0);
    check("ldst_op_count", op_count, exp_cnt);

    // start/load/address changes during busy are ignored
    do_load(2'd0, 8'h10);
    do_load(2'd1, 8'h22);
    op = 2'd0; a_addr = 2'd0; b_addr = 2'd1; c_addr = 2'd2;
    start = 1'b1;
    tick();
    start = 1'b0;
    dones = 0;
    tick();
    start = 1'b1; load = 1'b1; load_addr = 2'd3; load_data = 8'hAA;
    op = 2'd3; a_addr = 2'd3; b_addr = 2'd3; c_addr = 2'd1;
    tick();
    tick();
    start = 1'b0; load = 1'b0;
    if (done) dones++;
    for (int k = 0; k < 10; k++) begin
      tick();
      if (done) dones++;
    end
    exp_cnt = (exp_cnt + 1) % 256;
    check("busy_ign_dones", dones, 1);
    check("busy_ign_result", result, 8'h32);
    check("busy_ign_r2", rf(2), 8'h32);
    check("busy_ign_r3", rf(3), 8'h11);
    check("busy_ign_r1", rf(1), 8'h22);
    check("busy_ign_count", op_count, exp_cnt);

    // Reset in EXEC aborts the operation
    do_load(2'd3, 8'h55);
    op = 2'd0; a_addr = 2'd0; b_addr = 2'd1; c_addr = 2'd3;
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    exp_cnt = 0;
    check("abort_r3", rf(3), 0);
    check("abort_busy", busy, 0);
    check("abort_result", result, 0);
    check("abort_carry", carry_out, 0);
    check("abort_zero", zero, 0);
    check("abort_count", op_count, 0);
    dones = 0;
    for (int k = 0; k < 6; k++) begin
      tick();
      if (done) dones++;
    end
    check("abort_no_done", dones, 0);
    check("abort_r3_still0", rf(3), 0);
    do_load(2'd0, 8'h05);
    do_load(2'd1, 8'h07);
    run_op(2'd1, 2'd0, 2'd1, 2'd3);
    check("after_abort_result", result, 8'hFE);
    check("after_abort_carry", carry_out, 1);
    check("after_abort_r3", rf(3), 8'hFE);
    check("after_abort_count", op_count, 1);

    // op_count wrap over 256 back-to-back operations
    do_reset();
    for (int i = 0; i < 255; i++) run_op(2'd3, 2'd0, 2'd0, 2'd0);
    check("wrap_255", op_count, 8'd255);
    run_op(2'd3, 2'd0, 2'd0, 2'd0);
    check("wrap_0", op_count, 8'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/alu_exec_unit.md
ALU_EXEC_UNIT -- requirements
Module: alu_exec_unit

Interface
REQ-001 SHALL have parameter WIDTH, default 8, meaning operand/result width in bits (legal 3..16).
REQ-002 SHALL have parameter AWIDTH, default 2, meaning register-file address width; depth = 2**AWIDTH words.
REQ-003 SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst, input, 1, reset; synchronous, active-high.
REQ-005 SHALL have port load, input, 1, external write strobe into the register file.
REQ-006 SHALL have port load_addr, input, AWIDTH, external write address.
REQ-007 SHALL have port load_data, input, WIDTH, external write data.
REQ-008 SHALL have port start, input, 1, request one operation.
REQ-009 SHALL have port op, input, 2, operation select: ADD=0, SUB=1, AND=2, OR=3.
REQ-010 SHALL have ports a_addr, b_addr, c_addr, input, AWIDTH each, for operand A, operand B and destination.
REQ-011 SHALL have port busy, output, 1, high while an operation is in flight.
REQ-012 SHALL have port done, output, 1, one-cycle completion pulse.
REQ-013 SHALL have ports result, output, WIDTH, and carry_out and zero, output, 1 each, holding the last completed result and flags.
REQ-014 SHALL have port op_count, output, 8, count of completed operations.

Function
REQ-015 SHALL implement FSM states IDLE, READ, EXEC, WRITE, DONE.
REQ-016 In IDLE with load=1: write load_data to load_addr at that edge and stay IDLE; a coincident start is ignored (load wins).
REQ-017 In IDLE with start=1 and load=0: capture op, a_addr, b_addr and c_addr, then go to READ; busy=1 from the next cycle.
REQ-018 READ: register RF[a] and RF[b] as operands; go to EXEC.
REQ-019 EXEC: compute and register result, carry_out and zero; go to WRITE.
REQ-020 ADD: {carry_out,result} = A+B at WIDTH+1 bits.
REQ-021 SUB: result = (A-B) mod 2**WIDTH; carry_out = 1 iff A<B (borrow).
REQ-022 AND/OR: bitwise result; carry_out = 0.
REQ-023 For all ops, zero = (result == 0).
REQ-024 WRITE: write result to captured c_addr and increment op_count modulo 256 (255 wraps to 0); go to DONE.
REQ-025 DONE: done=1 and busy=1 for exactly one cycle; return to IDLE.
REQ-026 Latency: start sampled at edge t gives done=1 during cycle t+4; back-to-back start is accepted in the cycle after DONE.
REQ-027 While busy: start, load and all address/op input changes are ignored.
REQ-028 c_addr equal to a_addr or b_addr is legal: operands are read before the write (e.g. r0 = r0 + r1).
REQ-029 result, carry_out and zero SHALL hold their values until the next EXEC.

Reset
REQ-030 rst=1 at an edge: FSM goes to IDLE; busy, done, result, carry_out, zero and op_count go to 0; all RF words go to 0.
REQ-031 rst has priority over load and start in the same cycle.
REQ-032 Reset during READ, EXEC or WRITE aborts the operation: no RF write follows and done does not pulse.

Structure
REQ-033 A shared package alu_exec_pkg SHALL hold the op encodings (OP_ADD, OP_SUB, OP_AND, OP_OR) and the FSM state enumeration.
REQ-034 The register file SHALL be one sub-module, alu_exec_rf: two combinational read ports, one synchronous write port, synchronous clear on rst.
REQ-035 The write port SHALL be shared between load (IDLE) and WRITE (FSM) through a mux selected by FSM state.

Verification (WIDTH=8, AWIDTH=2)
REQ-036 Load r0=0x7F and r1=0x01, then ADD a=0,b=1,c=2 -> done at t+4; result=0x80, carry_out=0, zero=0; r2=0x80; op_count=1.
REQ-037 Load r0=0xFF and r1=0x01, then ADD c=0 -> result=0x00, carry_out=1, zero=1; r0=0x00 (aliasing check).
REQ-038 r0=0x05 and r1=0x07: SUB -> result=0xFE, carry_out=1. AND of 0xF0 and 0x3C -> 0x30, carry_out=0.
REQ-039 Assert start and load together in IDLE -> RF written, no operation starts. Pulse start and load during busy -> both ignored; only one done pulse.
REQ-040 Assert rst in EXEC with destination r3=0x55 -> r3 becomes 0 (reset clear), no done pulse, all outputs 0, and the next start completes normally.
REQ-041 Run 256 back-to-back operations -> op_count reads 255, then wraps to 0 on the 256th WRITE.
